// File: rtl/muldiv_pkg.sv
// Shared constants for the EX-stage multiply/divide unit: MDFunc codes,
// FSM state encodings and the divide-by-zero quotient value.
package muldiv_pkg;

    localparam logic [1:0] MD_MUL  = 2'b00;
    localparam logic [1:0] MD_DIV  = 2'b01;
    localparam logic [1:0] MD_MTHI = 2'b10;
    localparam logic [1:0] MD_MTLO = 2'b11;

    localparam logic [1:0] MD_IDLE = 2'b00;
    localparam logic [1:0] MD_MULS = 2'b01;
    localparam logic [1:0] MD_DIVS = 2'b10;
    localparam logic [1:0] MD_FIX  = 2'b11;

    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFFFFFF;

endpackage

// File: rtl/muldiv_div_step.sv
// Combinational restoring-division step retiring BITS_PER_CYCLE quotient bits.
// The dividend enters through i_quo's MSBs and is replaced by quotient bits.
module muldiv_div_step #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [31:0] i_rem,
    input  logic [31:0] i_quo,
    input  logic [31:0] i_dvsr,
    output logic [31:0] o_rem,
    output logic [31:0] o_quo
);

    always_comb begin
        logic [32:0] v_shift;
        logic [31:0] v_rem;
        logic [31:0] v_quo;
        v_shift = '0;
        v_rem   = i_rem;
        v_quo   = i_quo;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            // Partial remainder is widened to 33 bits so the shifted-in bit never overflows.
            v_shift = {v_rem, v_quo[31]};
            if (v_shift >= {1'b0, i_dvsr}) begin
                v_shift = v_shift - {1'b0, i_dvsr};
                v_quo   = {v_quo[30:0], 1'b1};
            end else begin
                v_quo   = {v_quo[30:0], 1'b0};
            end
            v_rem = v_shift[31:0];
        end
        o_rem = v_rem;
        o_quo = v_quo;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier (IDLE -> FIX -> IDLE).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Signed,
    input  logic [1:0]  MDFunc,
    input  logic        Start,
    input  logic        Cancel,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Done,
    output logic [1:0]  DbgState
);

    localparam int         N_ITER   = 32 / BITS_PER_CYCLE;
    localparam logic [4:0] CNT_LAST = 5'(N_ITER - 1);

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] r_prod;
    logic [31:0] r_mcand;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvsr;
    logic        r_is_div;
    logic        r_neg;
    logic        r_sign_a;

    logic        w_sign_a;
    logic        w_sign_b;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [63:0] w_prod_next;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_sign_a = Signed & A[31];
    assign w_sign_b = Signed & B[31];
    assign w_a_mag  = w_sign_a ? (32'd0 - A) : A;
    assign w_b_mag  = w_sign_b ? (32'd0 - B) : B;

    // Shift-add: low half starts as the multiplier and drains out to the right.
    always_comb begin
        logic [32:0] v_sum;
        v_sum       = '0;
        w_prod_next = r_prod;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            v_sum       = {1'b0, w_prod_next[63:32]} + (w_prod_next[0] ? {1'b0, r_mcand} : 33'd0);
            w_prod_next = {v_sum, w_prod_next[31:1]};
        end
    end

    muldiv_div_step #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_div_step (
        .i_rem  (r_rem),
        .i_quo  (r_quo),
        .i_dvsr (r_dvsr),
        .o_rem  (w_rem_next),
        .o_quo  (w_quo_next)
    );

    // Divide by zero forces the all-ones quotient regardless of operand signs.
    assign w_prod_fix = r_neg ? (64'd0 - r_prod) : r_prod;
    assign w_quo_fix  = (r_dvsr == 32'd0) ? DIV0_QUOTIENT : (r_neg ? (32'd0 - r_quo) : r_quo);
    assign w_rem_fix  = r_sign_a ? (32'd0 - r_rem) : r_rem;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= MD_IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
            r_is_div <= 1'b0;
            r_neg    <= 1'b0;
            r_sign_a <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MD_IDLE: begin
                    if (Start && !Cancel) begin
                        case (MDFunc)
                            MD_MTHI: r_hi <= A;
                            MD_MTLO: r_lo <= A;
                            default: begin
                                r_busy   <= 1'b1;
                                r_neg    <= w_sign_a ^ w_sign_b;
                                r_sign_a <= w_sign_a;
                                r_is_div <= (MDFunc == MD_DIV);
                                r_cnt    <= CNT_LAST;
                                if (MDFunc == MD_DIV) begin
                                    r_rem   <= '0;
                                    r_quo   <= w_a_mag;
                                    r_dvsr  <= w_b_mag;
                                    r_state <= MD_DIVS;
                                end else begin
                                    r_mcand <= w_a_mag;
`ifdef MULDIV_FAST_MUL_EN
                                    r_prod  <= 64'(w_a_mag) * 64'(w_b_mag);
                                    r_state <= MD_FIX;
`else
                                    r_prod  <= {32'd0, w_b_mag};
                                    r_state <= MD_MULS;
`endif
                                end
                            end
                        endcase
                    end
                end
                MD_MULS, MD_DIVS: begin
                    if (Cancel) begin
                        r_state <= MD_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        if (r_state == MD_MULS) begin
                            r_prod <= w_prod_next;
                        end else begin
                            r_rem <= w_rem_next;
                            r_quo <= w_quo_next;
                        end
                        if (r_cnt == 5'd0) begin
                            r_state <= MD_FIX;
                        end else begin
                            r_cnt <= r_cnt - 5'd1;
                        end
                    end
                end
                MD_FIX: begin
                    r_state <= MD_IDLE;
                    r_busy  <= 1'b0;
                    if (!Cancel) begin
                        r_done <= 1'b1;
                        if (r_is_div) begin
                            r_lo <= w_quo_fix;
                            r_hi <= w_rem_fix;
                        end else begin
                            r_lo <= w_prod_fix[31:0];
                            r_hi <= w_prod_fix[63:32];
                        end
                    end
                end
                default: begin
                    r_state <= MD_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign HI       = r_hi;
    assign LO       = r_lo;
    assign Busy     = r_busy;
    assign Done     = r_done;
    assign DbgState = r_state;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers, placed in the EX stage beside the ALU.
- Takes the same forwarded A/B operands and Signed flag as the ALU and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- HI/LO feed the EX result mux for MFHI/MFLO.
- Busy drives the hazard unit, which stalls any later HI/LO access or new mul/div.

Parameters:
- BITS_PER_CYCLE, 1, quotient/multiplier bits retired per iteration cycle. Legal values: 1, 2, 4. N = 32/BITS_PER_CYCLE iteration cycles.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous active-low reset
- A  in  32  operand rs (dividend / multiplicand / MTHI-MTLO source)
- B  in  32  operand rt (divisor / multiplier)
- Signed  in  1  1 = signed operation, 0 = unsigned
- MDFunc  in  2  operation: 00 MUL, 01 DIV, 10 MTHI, 11 MTLO
- Start  in  1  single-cycle request, sampled on the clock edge
- Cancel  in  1  abort the in-flight operation (pipeline flush)
- HI  out  32  HI register
- LO  out  32  LO register
- Busy  out  1  operation in flight
- Done  out  1  one-cycle pulse when HI/LO have just been updated by MUL/DIV

Behaviour:
- Reset (asynchronous, reset=0): HI=0, LO=0, Busy=0, Done=0, state=IDLE, datapath registers cleared.
- Reset mid-operation: immediate return to IDLE. HI/LO are cleared; no partial result is written.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - Start with MDFunc=MTHI/MTLO: HI/LO <= A at that edge. Busy stays 0, no Done pulse.
  - Start with MDFunc=MUL: capture |A|, |B| (magnitudes if Signed, raw otherwise) and the result sign; go to MUL.
  - Start with MDFunc=DIV: same capture as MUL; go to DIV.
- MUL:
  - Shift-add, BITS_PER_CYCLE multiplier bits per cycle, 64-bit accumulator.
  - After N cycles go to FIX.
- DIV:
  - Restoring division, BITS_PER_CYCLE quotient bits per cycle, 33-bit partial remainder.
  - After N cycles go to FIX.
- FIX:
  - Apply signs: product negated if sign(A)^sign(B); quotient negated if sign(A)^sign(B); remainder takes sign(A).
  - HI/LO written at the FIX exit edge: MUL gives HI=product[63:32], LO=product[31:0]; DIV gives LO=quotient, HI=remainder.
  - Return to IDLE.
- Busy: 1 in MUL, DIV and FIX, so exactly N+1 cycles after the Start edge. Registered output.
- Done: 1 for the single cycle after the FIX exit edge, when the new HI/LO are already visible.
- Start while Busy=1: ignored (hazard unit contract). The bench flags it as a protocol violation.
- Cancel while Busy=1: return to IDLE at the next edge; HI/LO unchanged; no Done.
- Cancel in IDLE: no effect.
- Cancel and Start in the same IDLE cycle: Cancel wins and the request is dropped.
- Divide by zero (B==0 at Start, either signedness): after the normal N+1 cycles, LO=0xFFFFFFFF, HI=A. Fixed override, not a sign-fix artefact.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- Operand magnitude 0x80000000 is held in 33 bits; no overflow is possible internally.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined: MUL computes the full 64-bit product in one cycle with a single multiplier, going IDLE -> FIX -> IDLE. Busy is high for 1 cycle and Done follows. DIV timing is unchanged.
- Undefined: MUL is iterative as above (N+1 cycles), and no multiplier primitive is inferred.

Decomposition:
- Shared package muldiv_pkg:
  - MDFunc codes MD_MUL, MD_DIV, MD_MTHI, MD_MTLO.
  - State enum MD_IDLE/MD_MUL/MD_DIV/MD_FIX.
  - Constant DIV0_QUOTIENT=32'hFFFFFFFF.
- Sub-module muldiv_div_step: combinational restoring-division step retiring BITS_PER_CYCLE bits (remainder, quotient in; remainder, quotient out). Instantiated once inside muldiv_unit.

Test Plan:
- Unsigned MUL, A=0xFFFFFFFF, B=0xFFFFFFFF, BITS_PER_CYCLE=1 -> Busy high exactly 33 cycles, then Done pulse with HI=0xFFFFFFFE, LO=0x00000001.
- Signed MUL, A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Repeat with MULDIV_FAST_MUL_EN defined -> Busy exactly 1 cycle, same result.
- Signed DIV, A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Unsigned DIV of the same operands -> LO=0x7FFFFFFC, HI=0x00000001.
- DIV with B=0, A=0x12345678 -> LO=0xFFFFFFFF, HI=0x12345678. Signed 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI A=0xAAAA5555, then MTLO A=0x1 on consecutive cycles -> HI/LO updated at each edge, Busy never asserts. Then DIV started and Cancel asserted on cycle 10 -> Busy low next cycle, HI/LO still 0xAAAA5555/0x1, no Done.
- reset pulled low on cycle 5 of a MUL -> HI=LO=0, Busy=0 immediately (asynchronous). A fresh MUL after release completes normally.
